// File: rtl/universal_shift_register.sv
// Universal shift register: parallel load plus multi-step shifts in eight modes.
// Latency: start at edge E0 with shamt=n>0 shifts one bit per edge on E1..En,
//          then done pulses for one cycle.
// Backpressure: none. start and load_en are ignored while busy is high.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   load_en  parallel-load request (idle only); d_in is the load data
//   start    start-shift request (idle only); samples mode and shamt
//   mode     000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101 SIL, 110 SIR, 111 hold
//   shamt    number of 1-bit steps
//   ser_in   serial fill bit for SIL/SIR, sampled on every step
//   q_out    register contents
//   ser_out  bit at the exit end of the register for the latched mode
//   busy     high while shift steps remain
//   done     one-cycle completion pulse
module universal_shift_register #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] shamt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_LSR = 3'd1;
  localparam logic [2:0] MODE_ASR = 3'd2;
  localparam logic [2:0] MODE_ROL = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;
  localparam logic [2:0] MODE_SIL = 3'd5;
  localparam logic [2:0] MODE_SIR = 3'd6;

  state_t             state, state_n;
  logic [WIDTH-1:0]   q_reg, q_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         mode_reg, mode_n;
  logic               done_reg, done_n;

  // One 1-bit step of the given mode. The reserved code holds the value.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] v,
    input logic [2:0]       m,
    input logic             s
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      MODE_LSL: r = {v[WIDTH-2:0], 1'b0};
      MODE_LSR: r = {1'b0, v[WIDTH-1:1]};
      MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
      MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROR: r = {v[0], v[WIDTH-1:1]};
      MODE_SIL: r = {v[WIDTH-2:0], s};
      MODE_SIR: r = {s, v[WIDTH-1:1]};
      default:  r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_n = state;
    q_n     = q_reg;
    cnt_n   = cnt;
    mode_n  = mode_reg;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        // Load first so a same-cycle start shifts the freshly loaded value.
        if (load_en) begin
          q_n = d_in;
        end
        if (start) begin
          mode_n = mode;
          if (shamt != '0) begin
            state_n = SHIFT;
            cnt_n   = shamt;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      SHIFT: begin
        q_n   = shift_step(q_reg, mode_reg, ser_in);
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      q_reg    <= '0;
      cnt      <= '0;
      mode_reg <= MODE_LSL;
      done_reg <= 1'b0;
    end else begin
      state    <= state_n;
      q_reg    <= q_n;
      cnt      <= cnt_n;
      mode_reg <= mode_n;
      done_reg <= done_n;
    end
  end

  assign q_out = q_reg;
  assign busy  = (state == SHIFT);
  assign done  = done_reg;

  // Left-moving modes push bits out of the MSB; all others out of the LSB.
  assign ser_out = (mode_reg == MODE_LSL || mode_reg == MODE_ROL || mode_reg == MODE_SIL)
                   ? q_reg[WIDTH-1] : q_reg[0];

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int unsigned MODV = 32'd65536;
  localparam int unsigned HALF = 32'd32768;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_en;
  logic [WIDTH-1:0] d_in;
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] shamt;
  logic             ser_in;
  logic [WIDTH-1:0] q_out;
  logic             ser_out;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: register value, steps still to run, latched mode, done flag.
  int unsigned m_q = 0, m_left = 0, m_mode = 0, m_done = 0;

  universal_shift_register #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .load_en (load_en),
    .d_in    (d_in),
    .start   (start),
    .mode    (mode),
    .shamt   (shamt),
    .ser_in  (ser_in),
    .q_out   (q_out),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step described with integer arithmetic on a 16-bit value.
  function automatic int unsigned ref_step(int unsigned v, int unsigned m, int unsigned s);
    case (m)
      0: return (v * 2) % MODV;
      1: return v / 2;
      2: return v / 2 + ((v >= HALF) ? HALF : 0);
      3: return (v * 2) % MODV + v / HALF;
      4: return v / 2 + (v % 2) * HALF;
      5: return (v * 2) % MODV + s;
      6: return v / 2 + s * HALF;
      default: return v;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_q = 0; m_left = 0; m_mode = 0; m_done = 0;
    end else if (m_left == 0) begin
      m_done = 0;
      if (load_en) m_q = 32'(d_in);
      if (start) begin
        m_mode = 32'(mode);
        if (shamt == 0) m_done = 1;
        else m_left = 32'(shamt);
      end
    end else begin
      m_q = ref_step(m_q, m_mode, 32'(ser_in));
      m_left--;
      m_done = (m_left == 0) ? 1 : 0;
    end
  endtask

  // Advance one edge and compare every output with the reference.
  task automatic cycle();
    int unsigned exp_so;
    model_edge();
    @(posedge clk);
    #1;
    exp_so = (m_mode == 0 || m_mode == 3 || m_mode == 5) ? m_q / HALF : m_q % 2;
    chk("model_q", 32'(q_out), m_q);
    chk("model_busy", 32'(busy), (m_left != 0) ? 32'd1 : 32'd0);
    chk("model_done", 32'(done), m_done);
    chk("model_ser_out", 32'(ser_out), exp_so);
  endtask

  task automatic go(input logic ld, input logic [15:0] dv, input logic st,
                    input logic [2:0] md, input logic [4:0] sa);
    load_en = ld; d_in = dv; start = st; mode = md; shamt = sa;
    cycle();
    load_en = 1'b0; start = 1'b0;
  endtask

  initial begin
    int dones;
    logic [15:0] rol_exp [4];
    rol_exp[0] = 16'h0003; rol_exp[1] = 16'h0006; rol_exp[2] = 16'h000C; rol_exp[3] = 16'h0018;

    reset = 1'b1; load_en = 1'b0; d_in = '0; start = 1'b0; mode = '0; shamt = '0; ser_in = 1'b0;
    cycle();
    chk("reset_q", 32'(q_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    reset = 1'b0;

    // Rotate left by 4 from 0x8001.
    go(1'b1, 16'h8001, 1'b0, 3'd0, 5'd0);
    go(1'b0, 16'h0, 1'b1, 3'd3, 5'd4);
    chk("rol_busy_after_start", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rol_step_q", 32'(q_out), 32'(rol_exp[i]));
    end
    chk("rol_done", 32'(done), 32'h1);
    chk("rol_busy_end", 32'(busy), 32'h0);
    cycle();
    chk("rol_done_clear", 32'(done), 32'h0);

    // Arithmetic vs logical right shift of 0x8000 by 3.
    go(1'b1, 16'h8000, 1'b0, 3'd0, 5'd0);
    go(1'b0, 16'h0, 1'b1, 3'd2, 5'd3);
    repeat (3) cycle();
    chk("asr_q", 32'(q_out), 32'hF000);
    chk("asr_ser_out", 32'(ser_out), 32'h0);
    go(1'b1, 16'h8000, 1'b0, 3'd0, 5'd0);
    go(1'b0, 16'h0, 1'b1, 3'd1, 5'd3);
    repeat (3) cycle();
    chk("lsr_q", 32'(q_out), 32'h1000);

    // Zero shift amount: immediate done, never busy.
    go(1'b1, 16'h1234, 1'b0, 3'd0, 5'd0);
    go(1'b0, 16'h0, 1'b1, 3'd1, 5'd0);
    chk("zero_busy", 32'(busy), 32'h0);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_q", 32'(q_out), 32'h1234);
    cycle();
    chk("zero_done_clear", 32'(done), 32'h0);

    // Serial-in left with ignored start/load during busy.
    go(1'b1, 16'h0000, 1'b0, 3'd0, 5'd0);
    ser_in = 1'b1;
    go(1'b0, 16'h0, 1'b1, 3'd5, 5'd2);
    dones = 0;
    load_en = 1'b1; d_in = 16'hFFFF; start = 1'b1; mode = 3'd4; shamt = 5'd7;
    cycle(); if (done) dones++;
    cycle(); if (done) dones++;
    load_en = 1'b0; start = 1'b0;
    chk("sil_q", 32'(q_out), 32'h0003);
    repeat (3) begin cycle(); if (done) dones++; end
    chk("sil_done_count", 32'(dones), 32'd1);

    // Reset in the middle of a shift.
    go(1'b1, 16'h00FF, 1'b0, 3'd0, 5'd0);
    go(1'b0, 16'h0, 1'b1, 3'd0, 5'd5);
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("abort_q", 32'(q_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    dones = 0;
    repeat (6) begin cycle(); if (done) dones++; end
    chk("abort_no_done", 32'(dones), 32'd0);

    // Load and start in one cycle; rotate past the width.
    go(1'b1, 16'h00FF, 1'b1, 3'd0, 5'd8);
    repeat (8) cycle();
    chk("ldst_q", 32'(q_out), 32'hFF00);
    chk("ldst_done", 32'(done), 32'h1);
    go(1'b1, 16'h0001, 1'b0, 3'd0, 5'd0);
    go(1'b0, 16'h0, 1'b1, 3'd3, 5'd20);
    repeat (20) cycle();
    chk("rol20_q", 32'(q_out), 32'h0010);

    // Back-to-back start in the done cycle.
    go(1'b1, 16'h0001, 1'b1, 3'd0, 5'd1);
    cycle();
    chk("b2b_done", 32'(done), 32'h1);
    go(1'b0, 16'h0, 1'b1, 3'd0, 5'd2);
    chk("b2b_busy", 32'(busy), 32'h1);
    repeat (2) cycle();
    chk("b2b_q", 32'(q_out), 32'h0008);

    // Random traffic against the reference.
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom % 80) == 0;
      load_en = ($urandom % 4) == 0;
      start   = ($urandom % 3) == 0;
      d_in    = 16'($urandom);
      mode    = 3'($urandom);
      shamt   = 5'($urandom);
      ser_in  = 1'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
